// File: rtl/ac97_pkg.sv
// ac97_pkg: shared types and constants for the AC'97 tone mixer.
// Holds the PCM sample format, duty-cycle codes, mixer states and the
// duty threshold helper used by the per-channel step logic.
package ac97_pkg;

  localparam int SAMPLE_W    = 20;
  localparam int LEVEL_SHIFT = 14;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 20'sh7FFFF;  // +524287
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 20'sh80000;  // -524288

  // Fraction of the period during which the square wave is high.
  typedef enum logic [1:0] {
    DUTY_12P5 = 2'b00,
    DUTY_25   = 2'b01,
    DUTY_50   = 2'b10,
    DUTY_75   = 2'b11
  } duty_e;

  // Serial mixer sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MIX  = 2'b01,
    SAT  = 2'b10
  } mix_state_e;

  // Phase threshold below which the output is high (floor division).
  function automatic int unsigned duty_threshold(input int unsigned rate, input duty_e duty);
    int unsigned t;
    case (duty)
      DUTY_12P5: t = rate / 8;
      DUTY_25:   t = rate / 4;
      DUTY_50:   t = rate / 2;
      default:   t = (3 * rate) / 4;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ac97_tone_step.sv
// ac97_tone_step: combinational single-channel step.
// Advances one channel's phase by its frequency with remainder-preserving
// wrap at STROBE_RATE and produces the signed square-wave contribution.
// Instantiated once in the mixer and time-multiplexed across channels.
module ac97_tone_step
  import ac97_pkg::*;
#(
  parameter int ACC_W       = 20,
  parameter int STROBE_RATE = 48000
) (
  input  logic [ACC_W-1:0]           phase_i,
  input  logic [ACC_W-1:0]           freq_i,
  input  duty_e                      duty_i,
  input  logic [3:0]                 level_i,
  output logic [ACC_W-1:0]           phase_o,
  output logic signed [SAMPLE_W-1:0] contrib_o
);

  // One extra bit so phase + freq cannot overflow before the wrap compare.
  localparam logic [ACC_W:0] RATE = (ACC_W + 1)'(STROBE_RATE);

  logic [ACC_W:0]             sum;
  logic [ACC_W:0]             wrapped;
  logic [ACC_W-1:0]           next_phase;
  logic [ACC_W-1:0]           thresh;
  logic signed [SAMPLE_W-1:0] mag;

  // Phase advance with wrap by subtraction, then duty compare and sign select.
  always_comb begin
    sum        = {1'b0, phase_i} + {1'b0, freq_i};
    wrapped    = (sum >= RATE) ? (sum - RATE) : sum;
    next_phase = ACC_W'(wrapped);
    thresh     = ACC_W'(duty_threshold(STROBE_RATE, duty_i));
    mag        = SAMPLE_W'(level_i) << LEVEL_SHIFT;
    phase_o    = next_phase;
    contrib_o  = (next_phase < thresh) ? mag : -mag;
  end

endmodule

// File: rtl/ac97_tone_mixer.sv
// ac97_tone_mixer: N-channel square-wave tone generator and stereo mixer
// feeding AC'97 PCM slots 3 (left) and 4 (right).
// Each frame strobe presents the previously mixed sample and starts a
// serial mix: one channel per cycle, then one saturation cycle.
// Optional feature macro: AC97_TONE_MIXER_PAN_EN builds per-channel stereo
// pan; without it every channel feeds both sides and slot4 equals slot3.
module ac97_tone_mixer
  import ac97_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int STROBE_RATE = 48000,
  parameter int ACC_W       = 20
) (
  input  logic                                         ac97_bitclk,
  input  logic                                         rst,
  input  logic                                         ac97_strobe,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                             cfg_freq,
  input  logic [1:0]                                   cfg_duty,
  input  logic [3:0]                                   cfg_level,
  input  logic                                         cfg_enable,
  input  logic [1:0]                                   cfg_pan,
  output logic [SAMPLE_W-1:0]                          ac97_out_slot3,
  output logic [SAMPLE_W-1:0]                          ac97_out_slot4,
  output logic                                         clip,
  output logic                                         busy
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

  localparam logic [ACC_W-1:0]               FREQ_LIMIT = ACC_W'(STROBE_RATE);
  localparam logic [ACC_W-1:0]               FREQ_MAX   = ACC_W'(STROBE_RATE - 1);
  localparam logic signed [ACC_SUM_W-1:0]    ACC_MAX    = ACC_SUM_W'(SAMPLE_MAX);
  localparam logic signed [ACC_SUM_W-1:0]    ACC_MIN    = ACC_SUM_W'(SAMPLE_MIN);

  // ---------------------------------------------------------------------
  // Per-channel configuration and phase
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] freq_q  [NUM_CH];
  duty_e            duty_q  [NUM_CH];
  logic [3:0]       level_q [NUM_CH];
  logic             en_q    [NUM_CH];
  logic [ACC_W-1:0] phase_q [NUM_CH];
`ifdef AC97_TONE_MIXER_PAN_EN
  logic [1:0]       pan_q   [NUM_CH];
`endif

  // ---------------------------------------------------------------------
  // Mixer state
  // ---------------------------------------------------------------------
  mix_state_e                 state_q,    state_d;
  logic [CH_W-1:0]            idx_q,      idx_d;
  logic signed [ACC_SUM_W-1:0] acc_l_q,   acc_l_d;
  logic signed [ACC_SUM_W-1:0] acc_r_q,   acc_r_d;
  logic signed [SAMPLE_W-1:0] res_l_q,    res_l_d;
  logic signed [SAMPLE_W-1:0] res_r_q,    res_r_d;
  logic                       res_clip_q, res_clip_d;
  logic [SAMPLE_W-1:0]        slot3_q,    slot3_d;
  logic [SAMPLE_W-1:0]        slot4_q,    slot4_d;
  logic                       clip_q,     clip_d;

  logic                       cfg_hit;
  logic [ACC_W-1:0]           cfg_freq_sat;
  logic                       step_en;
  logic                       to_l;
  logic                       to_r;
  logic [ACC_W-1:0]           step_phase;
  logic signed [SAMPLE_W-1:0] step_contrib;

  assign cfg_hit      = cfg_we && (int'(cfg_ch) < NUM_CH);
  assign cfg_freq_sat = (cfg_freq >= FREQ_LIMIT) ? FREQ_MAX : cfg_freq;
  assign step_en      = (state_q == MIX) && en_q[idx_q];

`ifdef AC97_TONE_MIXER_PAN_EN
  assign to_l = pan_q[idx_q][1];
  assign to_r = pan_q[idx_q][0];
`else
  // Pan is not built: every channel feeds both sides.
  logic unused_cfg_pan;
  assign unused_cfg_pan = ^cfg_pan;
  assign to_l           = 1'b1;
  assign to_r           = 1'b1;
`endif

  // Single shared step datapath, addressed by the mix index.
  ac97_tone_step #(
    .ACC_W       (ACC_W),
    .STROBE_RATE (STROBE_RATE)
  ) u_step (
    .phase_i   (phase_q[idx_q]),
    .freq_i    (freq_q[idx_q]),
    .duty_i    (duty_q[idx_q]),
    .level_i   (level_q[idx_q]),
    .phase_o   (step_phase),
    .contrib_o (step_contrib)
  );

  // Channel register file: host writes and phase write-back from the mix.
  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      // NOTE: this small register file is reset explicitly because a reset
      // must silence every channel; a RAM-style array would not be cleared.
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        freq_q[i]  <= '0;
        duty_q[i]  <= DUTY_12P5;
        level_q[i] <= '0;
        en_q[i]    <= 1'b0;
        phase_q[i] <= '0;
`ifdef AC97_TONE_MIXER_PAN_EN
        pan_q[i]   <= '0;
`endif
      end
    end else begin
      if (step_en) begin
        phase_q[idx_q] <= step_phase;
      end
      // The mix already read pre-write values this cycle, so a write to the
      // channel being stepped only affects the next frame.
      if (cfg_hit) begin
        freq_q[cfg_ch]  <= cfg_freq_sat;
        duty_q[cfg_ch]  <= duty_e'(cfg_duty);
        level_q[cfg_ch] <= cfg_level;
        en_q[cfg_ch]    <= cfg_enable;
`ifdef AC97_TONE_MIXER_PAN_EN
        pan_q[cfg_ch]   <= cfg_pan;
`endif
        if (!cfg_enable) begin
          phase_q[cfg_ch] <= '0;
        end
      end
    end
  end

  function automatic logic signed [SAMPLE_W-1:0] clamp(input logic signed [ACC_SUM_W-1:0] a);
    if (a > ACC_MAX) begin
      return SAMPLE_MAX;
    end else if (a < ACC_MIN) begin
      return SAMPLE_MIN;
    end
    return SAMPLE_W'(a);
  endfunction

  function automatic logic overflows(input logic signed [ACC_SUM_W-1:0] a);
    return (a > ACC_MAX) || (a < ACC_MIN);
  endfunction

  // Mixer next-state: frame hand-off, serial accumulate, saturate.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    res_l_d    = res_l_q;
    res_r_d    = res_r_q;
    res_clip_d = res_clip_q;
    slot3_d    = slot3_q;
    slot4_d    = slot4_q;
    clip_d     = clip_q;

    unique case (state_q)
      IDLE: begin
        if (ac97_strobe) begin
          slot3_d = res_l_q;
          slot4_d = res_r_q;
          clip_d  = res_clip_q;
          idx_d   = '0;
          acc_l_d = '0;
          acc_r_d = '0;
          state_d = MIX;
        end
      end
      MIX: begin
        if (step_en && to_l) begin
          acc_l_d = acc_l_q + ACC_SUM_W'(step_contrib);
        end
        if (step_en && to_r) begin
          acc_r_d = acc_r_q + ACC_SUM_W'(step_contrib);
        end
        if (int'(idx_q) == NUM_CH - 1) begin
          state_d = SAT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SAT: begin
        res_l_d    = clamp(acc_l_q);
        res_r_d    = clamp(acc_r_q);
        res_clip_d = overflows(acc_l_q) || overflows(acc_r_q);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mixer state register; rst overrides any strobe or mix in flight.
  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      res_l_q    <= '0;
      res_r_q    <= '0;
      res_clip_q <= 1'b0;
      slot3_q    <= '0;
      slot4_q    <= '0;
      clip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      res_l_q    <= res_l_d;
      res_r_q    <= res_r_d;
      res_clip_q <= res_clip_d;
      slot3_q    <= slot3_d;
      slot4_q    <= slot4_d;
      clip_q     <= clip_d;
    end
  end

  assign ac97_out_slot3 = slot3_q;
  assign ac97_out_slot4 = slot4_q;
  assign clip           = clip_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/ac97_tone_mixer.md
# ac97_tone_mixer

Multi-channel square-wave tone generator and stereo mixer feeding AC'97 PCM slots 3 and 4, clocked from the codec bit clock and stepped once per AC-link frame. It is the parametrised successor of the single-channel square source. It adds N channels, selectable duty cycle, signed bipolar output, per-channel stereo pan, remainder-preserving phase wrap, and saturating mix. It sits between the host/register side and the AC-link serializer, in place of the single square source.

## Interface
- NUM_CH, 4, number of tone channels (1..64)
- STROBE_RATE, 48000, phase modulus (frame rate in Hz)
- ACC_W, 20, phase accumulator and frequency width
- ac97_bitclk  in  1  codec bit clock; the only clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- ac97_strobe  in  1  one-cycle frame pulse from the AC-link block (bit 0 of frame)
- cfg_we  in  1  channel configuration write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for write
- cfg_freq  in  ACC_W  phase increment per frame (= tone Hz)
- cfg_duty  in  2  00=12.5 %, 01=25 %, 10=50 %, 11=75 %
- cfg_level  in  4  amplitude
- cfg_enable  in  1  channel enable
- cfg_pan  in  2  bit1=left, bit0=right
- ac97_out_slot3  out  20  left sample, two's complement
- ac97_out_slot4  out  20  right sample, two's complement
- clip  out  1  saturation occurred in the frame now presented
- busy  out  1  serial mix in progress

## Operation
- Per-channel registers: freq, duty, level, enable, pan, phase[ACC_W]. All reset to 0.
- Write: on cfg_we the addressed channel's registers load in the same edge.
  - freq ≥ STROBE_RATE is stored as STROBE_RATE-1.
  - cfg_enable=0 also clears that channel's phase.
  - cfg_ch ≥ NUM_CH is ignored.
- Mix is a serial state machine: IDLE → MIX (one channel per cycle, idx 0..NUM_CH-1) → SAT (1 cycle) → IDLE.
  - ac97_strobe in IDLE: the result register is copied to the outputs and clip, then MIX starts at idx 0.
- In MIX, for enabled channel idx:
  - phase' = phase + freq. If phase' ≥ STROBE_RATE, phase' -= STROBE_RATE (wrap by subtraction, remainder kept). Store phase'.
  - Threshold T = STROBE_RATE/8, /4, /2, 3*STROBE_RATE/4 (floor) per duty.
  - Contribution v = +(level<<14) if phase' < T, else -(level<<14).
  - Disabled channels contribute 0 and their phase stays 0.
- Left accumulator adds v if pan[1]; right adds v if pan[0]. Accumulators are 20+$clog2(NUM_CH)+1 bits signed.
- SAT: each side is clamped to [-524288, 524287] into the result register. clip_r = either side clamped.
- A write landing on the edge where a channel is being mixed takes effect from the next frame for that channel's step; the mix uses the pre-write values.

## Timing
- Output latency: a sample computed in frame k appears on slot3/4 at the strobe of frame k+1. Outputs are stable for the whole frame.
- busy rises the cycle after strobe and falls after SAT; duration NUM_CH+1 cycles. Must be < 256.
- A strobe while busy=1 cannot occur for legal NUM_CH and is ignored.
- rst (any cycle, including mid-MIX) on the next edge:
  - state IDLE, busy=0
  - all channel registers and phases 0
  - accumulators, result, outputs and clip 0
- rst has priority over cfg_we and ac97_strobe.

## Configuration
- AC97_TONE_MIXER_PAN_EN defined: cfg_pan stored and applied per channel.
- Undefined: pan registers are not built, cfg_pan is ignored, every channel feeds both sides, and slot4 always equals slot3.

## Structure
- Package ac97_pkg holds:
  - SAMPLE_W=20
  - SAMPLE_MAX / SAMPLE_MIN
  - duty code enum
  - mixer state enum (IDLE, MIX, SAT)
- One sub-module, ac97_tone_step. It is combinational and instantiated once, time-multiplexed: phase, freq, duty, level in → phase', signed contribution out.

## Test plan
- Single channel, freq=12000, duty=50 %, level=15, pan=11: after four strobes, phases 12000/24000/36000/0 → slot3 = slot4 = +245760, -245760, -245760, +245760, each one frame late.
- freq=47999, enabled: phase 47999 then 47998 (wrap keeps remainder). Write freq=60000 → stored 47999.
- Four channels, level=15, duty=75 %, freq=0, enabled → slot3 = 0x7FFFF, clip=1. Set duty=12.5 %, freq=STROBE_RATE/2 → slot3 = 0x80000, clip=1.
- With AC97_TONE_MIXER_PAN_EN, ch0 pan=10, level=8, high phase → slot3 = +131072, slot4 = 0. Without the macro, both = +131072.
- Assert rst two cycles into MIX → next edge busy=0, outputs 0, clip=0. The following frame produces 0 until channels are rewritten.
- cfg_we on the same edge as the channel-0 mix step → frame k uses the old level, frame k+1 uses the new one.
